// File: rtl/ysyx_22041207_lsu_axi_bridge.sv
// LSU to AXI4-Lite master bridge: one read or write transaction in flight.
// Optional LSU_AXI_ERR_CHECK_EN: non-OKAY bresp/rresp sets sticky bus_err_o.
module ysyx_22041207_lsu_axi_bridge #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  w_valid_i,
    output logic                  w_ready_o,
    input  logic [ADDR_W-1:0]     w_addr_i,
    input  logic [DATA_W-1:0]     w_data_i,
    input  logic [DATA_W/8-1:0]   w_mask_i,
    output logic                  w_valid_o,
    input  logic                  w_ready_i,
    input  logic                  r_valid_i,
    output logic                  r_ready_o,
    input  logic [ADDR_W-1:0]     r_addr_i,
    input  logic [7:0]            r_size_i,
    output logic                  data_valid_o,
    input  logic                  data_ready_i,
    output logic [DATA_W-1:0]     data_read_o,
    output logic                  awvalid,
    input  logic                  awready,
    output logic [ADDR_W-1:0]     awaddr,
    output logic                  wvalid,
    input  logic                  wready,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    input  logic                  bvalid,
    output logic                  bready,
    input  logic [1:0]            bresp,
    output logic                  arvalid,
    input  logic                  arready,
    output logic [ADDR_W-1:0]     araddr,
    output logic [2:0]            arsize,
    input  logic                  rvalid,
    output logic                  rready,
    input  logic [DATA_W-1:0]     rdata,
    input  logic [1:0]            rresp,
    output logic                  bus_err_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR_REQ,
        S_WR_RESP,
        S_WR_DONE,
        S_RD_REQ,
        S_RD_RESP,
        S_RD_DONE
    } state_e;

    state_e                state_q, state_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;
    logic                  w_valid_q, w_valid_d;
    logic                  data_valid_q, data_valid_d;
    logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
    logic [ADDR_W-1:0]     araddr_q, araddr_d;
    logic [2:0]            arsize_q, arsize_d;
    logic [DATA_W-1:0]     data_q, data_d;
    logic                  err_q, err_d;
    logic                  idle;
    logic [2:0]            size_enc;

    assign idle      = (state_q == S_IDLE);
    assign w_ready_o = idle & w_valid_i;
    assign r_ready_o = idle & r_valid_i & ~w_valid_i;

    always_comb begin
        size_enc = 3'd3;
        case (r_size_i)
            8'd1:    size_enc = 3'd0;
            8'd2:    size_enc = 3'd1;
            8'd4:    size_enc = 3'd2;
            8'd8:    size_enc = 3'd3;
            default: size_enc = 3'd3;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        awvalid_d    = awvalid_q;
        wvalid_d     = wvalid_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        rready_d     = rready_q;
        w_valid_d    = w_valid_q;
        data_valid_d = data_valid_q;
        awaddr_d     = awaddr_q;
        wdata_d      = wdata_q;
        wstrb_d      = wstrb_q;
        araddr_d     = araddr_q;
        arsize_d     = arsize_q;
        data_d       = data_q;
        unique case (state_q)
            S_IDLE: begin
                if (w_ready_o) begin
                    awaddr_d  = w_addr_i;
                    wdata_d   = w_data_i;
                    wstrb_d   = w_mask_i;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    state_d   = S_WR_REQ;
                end else if (r_ready_o) begin
                    araddr_d  = r_addr_i;
                    arsize_d  = size_enc;
                    arvalid_d = 1'b1;
                    state_d   = S_RD_REQ;
                end
            end
            S_WR_REQ: begin
                // AW and W channels may be accepted in either order
                awvalid_d = awvalid_q & ~awready;
                wvalid_d  = wvalid_q & ~wready;
                if (!awvalid_d && !wvalid_d) begin
                    bready_d = 1'b1;
                    state_d  = S_WR_RESP;
                end
            end
            S_WR_RESP: begin
                if (bvalid) begin
                    bready_d  = 1'b0;
                    w_valid_d = 1'b1;
                    state_d   = S_WR_DONE;
                end
            end
            S_WR_DONE: begin
                if (w_ready_i) begin
                    w_valid_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            S_RD_REQ: begin
                if (arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = S_RD_RESP;
                end
            end
            S_RD_RESP: begin
                if (rvalid) begin
                    data_d       = rdata;
                    rready_d     = 1'b0;
                    data_valid_d = 1'b1;
                    state_d      = S_RD_DONE;
                end
            end
            S_RD_DONE: begin
                if (data_ready_i) begin
                    data_valid_d = 1'b0;
                    state_d      = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

`ifdef LSU_AXI_ERR_CHECK_EN
    always_comb begin
        err_d = err_q;
        if (state_q == S_WR_RESP && bvalid && bresp != 2'b00) err_d = 1'b1;
        if (state_q == S_RD_RESP && rvalid && rresp != 2'b00) err_d = 1'b1;
    end
`else
    logic unused_resp;
    assign unused_resp = ^{bresp, rresp};
    assign err_d = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            awvalid_q    <= 1'b0;
            wvalid_q     <= 1'b0;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            w_valid_q    <= 1'b0;
            data_valid_q <= 1'b0;
            awaddr_q     <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            araddr_q     <= '0;
            arsize_q     <= '0;
            data_q       <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            awvalid_q    <= awvalid_d;
            wvalid_q     <= wvalid_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            w_valid_q    <= w_valid_d;
            data_valid_q <= data_valid_d;
            awaddr_q     <= awaddr_d;
            wdata_q      <= wdata_d;
            wstrb_q      <= wstrb_d;
            araddr_q     <= araddr_d;
            arsize_q     <= arsize_d;
            data_q       <= data_d;
            err_q        <= err_d;
        end
    end

    assign awvalid      = awvalid_q;
    assign wvalid       = wvalid_q;
    assign bready       = bready_q;
    assign arvalid      = arvalid_q;
    assign rready       = rready_q;
    assign w_valid_o    = w_valid_q;
    assign data_valid_o = data_valid_q;
    assign awaddr       = awaddr_q;
    assign wdata        = wdata_q;
    assign wstrb        = wstrb_q;
    assign araddr       = araddr_q;
    assign arsize       = arsize_q;
    assign data_read_o  = data_q;
    assign bus_err_o    = err_q;

endmodule

// File: tb/tb_ysyx_22041207_lsu_axi_bridge.sv
// Self-checking bench for the LSU AXI4-Lite bridge with a stalling slave model.
module tb_ysyx_22041207_lsu_axi_bridge;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        w_valid_i, w_ready_o, w_valid_o, w_ready_i;
    logic [63:0] w_addr_i, w_data_i;
    logic [7:0]  w_mask_i;
    logic        r_valid_i, r_ready_o;
    logic [63:0] r_addr_i;
    logic [7:0]  r_size_i;
    logic        data_valid_o, data_ready_i;
    logic [63:0] data_read_o;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [63:0] awaddr, wdata, araddr, rdata;
    logic [7:0]  wstrb;
    logic [2:0]  arsize;
    logic [1:0]  bresp, rresp;
    logic        bus_err_o;

    ysyx_22041207_lsu_axi_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .w_valid_i(w_valid_i), .w_ready_o(w_ready_o),
        .w_addr_i(w_addr_i), .w_data_i(w_data_i), .w_mask_i(w_mask_i),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o),
        .r_addr_i(r_addr_i), .r_size_i(r_size_i),
        .data_valid_o(data_valid_o), .data_ready_i(data_ready_i),
        .data_read_o(data_read_o),
        .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
        .wvalid(wvalid), .wready(wready), .wdata(wdata), .wstrb(wstrb),
        .bvalid(bvalid), .bready(bready), .bresp(bresp),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arsize(arsize),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
        .bus_err_o(bus_err_o)
    );

    int checks = 0;
    int errors = 0;

`ifdef LSU_AXI_ERR_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    // slave configuration
    int          aw_stall = 0, w_stall = 0, b_stall = 0;
    int          ar_stall = 0, r_stall = 0;
    logic [63:0] s_rdata = '0;
    logic [1:0]  s_bresp = 2'b00, s_rresp = 2'b00;

    // handshake monitor
    int          aw_hs, w_hs, b_hs, ar_hs, r_hs, pend_b, pend_r;
    logic        got_aw, got_w;
    logic [63:0] cap_awaddr, cap_wdata, cap_araddr;
    logic [7:0]  cap_wstrb;
    logic [2:0]  cap_arsize;
    logic        aw_now, w_now, b_now, ar_now, r_now, new_b;

    assign aw_now = awvalid & awready;
    assign w_now  = wvalid & wready;
    assign b_now  = bvalid & bready;
    assign ar_now = arvalid & arready;
    assign r_now  = rvalid & rready;
    assign new_b  = (got_aw | aw_now) & (got_w | w_now);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aw_hs <= 0; w_hs <= 0; b_hs <= 0; ar_hs <= 0; r_hs <= 0;
            pend_b <= 0; pend_r <= 0; got_aw <= 1'b0; got_w <= 1'b0;
        end else begin
            if (aw_now) begin aw_hs <= aw_hs + 1; cap_awaddr <= awaddr; end
            if (w_now) begin
                w_hs <= w_hs + 1; cap_wdata <= wdata; cap_wstrb <= wstrb;
            end
            if (ar_now) begin
                ar_hs <= ar_hs + 1; cap_araddr <= araddr; cap_arsize <= arsize;
            end
            if (b_now) b_hs <= b_hs + 1;
            if (r_now) r_hs <= r_hs + 1;
            if (new_b) begin
                got_aw <= 1'b0; got_w <= 1'b0;
            end else begin
                if (aw_now) got_aw <= 1'b1;
                if (w_now)  got_w  <= 1'b1;
            end
            pend_b <= pend_b + int'(new_b) - int'(b_now);
            pend_r <= pend_r + int'(ar_now) - int'(r_now);
        end
    end

    // slave driver: readies/valids change on the falling edge
    initial begin
        int aw_c, w_c, ar_c, b_c, r_c;
        awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
        bresp = 0; rresp = 0; rdata = 0;
        aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                awready = 0; wready = 0; arready = 0; bvalid = 0; rvalid = 0;
                aw_c = 0; w_c = 0; ar_c = 0; b_c = 0; r_c = 0;
            end else begin
                if (awvalid) begin awready = (aw_c >= aw_stall); aw_c++; end
                else begin awready = 0; aw_c = 0; end
                if (wvalid) begin wready = (w_c >= w_stall); w_c++; end
                else begin wready = 0; w_c = 0; end
                if (arvalid) begin arready = (ar_c >= ar_stall); ar_c++; end
                else begin arready = 0; ar_c = 0; end
                if (pend_b > 0) begin
                    bvalid = (b_c >= b_stall); bresp = s_bresp; b_c++;
                end else begin bvalid = 0; b_c = 0; end
                if (pend_r > 0) begin
                    rvalid = (r_c >= r_stall); rdata = s_rdata;
                    rresp = s_rresp; r_c++;
                end else begin rvalid = 0; r_c = 0; end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // bready may only rise once both address and data were accepted
    initial forever begin
        @(negedge clk);
        if (rst_n && bready) chk("bready_before_aw_w", {awvalid, wvalid}, 0);
    end

    // arsize from the access size: log2 of a legal size, otherwise 8-byte
    function automatic logic [2:0] ref_arsize(input logic [7:0] sz);
        if (sz == 1 || sz == 2 || sz == 4 || sz == 8) return 3'($clog2(sz));
        return 3'd3;
    endfunction

    task automatic do_write(input logic [63:0] a, input logic [63:0] d,
                            input logic [7:0] m, input int hold);
        int n;
        int aw0, b0;
        aw0 = aw_hs; b0 = b_hs;
        @(negedge clk);
        w_valid_i = 1; w_addr_i = a; w_data_i = d; w_mask_i = m;
        #1;
        n = 0;
        while (!w_ready_o && n < 50) begin @(negedge clk); #1; n++; end
        chk("wr_accept", w_ready_o, 1);
        @(posedge clk); #1 w_valid_i = 0;
        n = 0;
        while (!w_valid_o && n < 100) begin @(negedge clk); n++; end
        chk("wr_complete", w_valid_o, 1);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk); chk("wr_hold", w_valid_o, 1);
        end
        w_ready_i = 1;
        @(posedge clk); #1 w_ready_i = 0;
        chk("wr_clear", w_valid_o, 0);
        chk("awaddr", cap_awaddr, a);
        chk("wdata", cap_wdata, d);
        chk("wstrb", cap_wstrb, m);
        chk("aw_count", aw_hs - aw0, 1);
        chk("b_count", b_hs - b0, 1);
    endtask

    task automatic do_read(input logic [63:0] a, input logic [7:0] sz,
                           input logic [63:0] rd, input logic [2:0] exp_sz,
                           input int hold);
        int n;
        int ar0;
        ar0 = ar_hs;
        s_rdata = rd;
        @(negedge clk);
        r_valid_i = 1; r_addr_i = a; r_size_i = sz;
        #1;
        n = 0;
        while (!r_ready_o && n < 50) begin @(negedge clk); #1; n++; end
        chk("rd_accept", r_ready_o, 1);
        @(posedge clk); #1 r_valid_i = 0;
        n = 0;
        while (!data_valid_o && n < 100) begin @(negedge clk); n++; end
        chk("rd_valid", data_valid_o, 1);
        chk("rd_data", data_read_o, rd);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk("rd_hold_valid", data_valid_o, 1);
            chk("rd_hold_data", data_read_o, rd);
        end
        data_ready_i = 1;
        @(posedge clk); #1 data_ready_i = 0;
        chk("rd_clear", data_valid_o, 0);
        chk("rd_keep", data_read_o, rd);
        chk("araddr", cap_araddr, a);
        chk("arsize", cap_arsize, exp_sz);
        chk("ar_count", ar_hs - ar0, 1);
    endtask

    typedef struct {
        logic [63:0] addr;
        logic [7:0]  size;
        logic [63:0] rd;
        logic [2:0]  exp_sz;
    } rd_vec_t;

    rd_vec_t vecs[6];

    initial begin
        int n;
        logic [63:0] last_rd;
        vecs[0] = '{64'h0000_0000_8000_0001, 8'd1, 64'h0123_4567_89AB_CDEF, 3'd0};
        vecs[1] = '{64'h0000_0000_8000_0102, 8'd2, 64'hFFFF_0000_FFFF_0000, 3'd1};
        vecs[2] = '{64'h0000_0000_8000_0204, 8'd4, 64'h5555_AAAA_5555_AAAA, 3'd2};
        vecs[3] = '{64'h0000_0000_8000_0308, 8'd8, 64'hA5A5_5A5A_0F0F_F0F0, 3'd3};
        vecs[4] = '{64'h0000_0000_8000_0403, 8'd3, 64'h0000_0000_0000_0001, 3'd3};
        vecs[5] = '{64'h0000_0000_8000_0500, 8'd0, 64'h8000_0000_0000_0000, 3'd3};

        rst_n = 0;
        w_valid_i = 0; w_addr_i = 0; w_data_i = 0; w_mask_i = 0; w_ready_i = 0;
        r_valid_i = 0; r_addr_i = 0; r_size_i = 0; data_ready_i = 0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_valids", {awvalid, wvalid, bready, arvalid, rready,
                           w_valid_o, data_valid_o}, 0);
        chk("rst_addrs", awaddr | araddr, 0);
        chk("rst_wdata", wdata, 0);
        chk("rst_rdata", data_read_o, 0);
        chk("rst_misc", {wstrb, arsize, bus_err_o}, 0);
        @(negedge clk) rst_n = 1;

        // zero-wait write timing
        @(negedge clk);
        w_valid_i = 1; w_addr_i = 64'h8000_0010;
        w_data_i = 64'h1122_3344_5566_7788; w_mask_i = 8'hFF;
        #1 chk("zw_w_ready", w_ready_o, 1);
        @(posedge clk); #1 w_valid_i = 0;
        chk("zw_aw_w_valid", {awvalid, wvalid}, 2'b11);
        chk("zw_awaddr", awaddr, 64'h8000_0010);
        chk("zw_wdata", wdata, 64'h1122_3344_5566_7788);
        chk("zw_wstrb", wstrb, 8'hFF);
        @(posedge clk); #1;
        chk("zw_bready", {bready, w_valid_o}, 2'b10);
        @(posedge clk); #1;
        chk("zw_w_valid_o", {bready, w_valid_o}, 2'b01);
        w_ready_i = 1;
        @(posedge clk); #1 w_ready_i = 0;
        chk("zw_w_done", w_valid_o, 0);

        // zero-wait read timing with held read data
        @(negedge clk);
        s_rdata = 64'hDEAD_BEEF_CAFE_F00D;
        r_valid_i = 1; r_addr_i = 64'h8000_0008; r_size_i = 8'd4;
        #1 chk("zr_r_ready", r_ready_o, 1);
        @(posedge clk); #1 r_valid_i = 0;
        chk("zr_arvalid", arvalid, 1);
        chk("zr_arsize", arsize, 3'd2);
        @(posedge clk); #1 chk("zr_rready", {rready, data_valid_o}, 2'b10);
        @(posedge clk); #1 chk("zr_data_valid", data_valid_o, 1);
        chk("zr_data", data_read_o, 64'hDEAD_BEEF_CAFE_F00D);
        repeat (2) begin
            @(posedge clk); #1 chk("zr_hold", data_valid_o, 1);
        end
        data_ready_i = 1;
        @(posedge clk); #1 data_ready_i = 0;
        chk("zr_done", data_valid_o, 0);

        // read with arready stalled 3 cycles, data held 2 cycles
        ar_stall = 3;
        do_read(64'h8000_0008, 8'd4, 64'hDEAD_BEEF_CAFE_F00D, 3'd2, 2);
        ar_stall = 0;

        foreach (vecs[i])
            do_read(vecs[i].addr, vecs[i].size, vecs[i].rd, vecs[i].exp_sz, 0);

        // simultaneous requests: write first, read right after completion
        @(negedge clk);
        w_valid_i = 1; w_addr_i = 64'h8000_0100; w_data_i = 64'h99;
        w_mask_i = 8'h0F;
        r_valid_i = 1; r_addr_i = 64'h8000_0200; r_size_i = 8'd8;
        s_rdata = 64'h7777_6666_5555_4444;
        #1 chk("tie_ready", {w_ready_o, r_ready_o}, 2'b10);
        @(posedge clk); #1 w_valid_i = 0;
        n = 0;
        while (!w_valid_o && n < 50) begin @(negedge clk); n++; end
        chk("tie_w_done", {w_valid_o, r_ready_o}, 2'b10);
        w_ready_i = 1;
        @(posedge clk); #1 w_ready_i = 0;
        chk("tie_r_accept", r_ready_o, 1);
        @(posedge clk); #1 r_valid_i = 0;
        chk("tie_arvalid", arvalid, 1);
        n = 0;
        while (!data_valid_o && n < 50) begin @(negedge clk); n++; end
        chk("tie_rd_data", data_read_o, 64'h7777_6666_5555_4444);
        data_ready_i = 1;
        @(posedge clk); #1 data_ready_i = 0;

        // W accepted two cycles before AW
        aw_stall = 2; w_stall = 0;
        do_write(64'h8000_0333, 64'hCAFE_0000_BEEF_1111, 8'h3C, 1);
        aw_stall = 0; w_stall = 2;
        do_write(64'h8000_0444, 64'h0, 8'h01, 0);
        w_stall = 0;

        // randomized traffic
        last_rd = data_read_o;
        for (int it = 0; it < 30; it++) begin
            logic [7:0] sz;
            logic [63:0] a, d;
            aw_stall = $urandom_range(0, 3); w_stall = $urandom_range(0, 3);
            b_stall  = $urandom_range(0, 3); ar_stall = $urandom_range(0, 3);
            r_stall  = $urandom_range(0, 3);
            a = {$urandom, $urandom}; d = {$urandom, $urandom};
            chk("rnd_data_keep", data_read_o, last_rd);
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, d, 8'($urandom), $urandom_range(0, 2));
            end else begin
                case ($urandom_range(0, 4))
                    0: sz = 8'd1;
                    1: sz = 8'd2;
                    2: sz = 8'd4;
                    3: sz = 8'd8;
                    default: sz = 8'($urandom);
                endcase
                do_read(a, sz, d, ref_arsize(sz), $urandom_range(0, 2));
                last_rd = d;
            end
        end
        aw_stall = 0; w_stall = 0; b_stall = 0; ar_stall = 0; r_stall = 0;

        // error response
        chk("err_clear", bus_err_o, 0);
        s_rresp = 2'b10;
        do_read(64'h8000_0600, 8'd8, 64'h1234, 3'd3, 0);
        s_rresp = 2'b00;
        chk("err_set", bus_err_o, EXP_ERR);
        do_read(64'h8000_0608, 8'd8, 64'h5678, 3'd3, 0);
        chk("err_sticky", bus_err_o, EXP_ERR);

        // reset while waiting for the write response
        b_stall = 6;
        @(negedge clk);
        w_valid_i = 1; w_addr_i = 64'h8000_0700; w_data_i = 64'h1; w_mask_i = 8'hFF;
        @(posedge clk); #1 w_valid_i = 0;
        n = 0;
        while (!bready && n < 20) begin @(negedge clk); n++; end
        chk("rst_mid_bready", bready, 1);
        @(negedge clk);
        rst_n = 0;
        #1 chk("rst_mid_valids", {awvalid, wvalid, bready, arvalid, rready,
                                  w_valid_o, data_valid_o}, 0);
        chk("rst_mid_err", bus_err_o, 0);
        repeat (2) @(negedge clk);
        rst_n = 1; b_stall = 0;
        repeat (3) begin
            @(negedge clk); chk("rst_no_complete", w_valid_o, 0);
        end
        do_read(64'h8000_0800, 8'd2, 64'hABCD_EF01_2345_6789, 3'd1, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22041207_lsu_axi_bridge.md
# ysyx_22041207_lsu_axi_bridge

Downstream of the memory-access stage: converts its valid/ready read and write requests into AXI4-Lite master transactions toward the data-side crossbar/SRAM. Holds exactly one transaction in flight and returns either a write-complete handshake or registered read data. Whole 64-bit beats only; byte-lane shifting and sign extension stay in the memory stage.

## Interface
- ADDR_W, 64, address width; DATA_W, 64, data width (STRB = DATA_W/8)
- clk  in  1  clock, all state on posedge
- rst_n  in  1  asynchronous, active-low reset
- w_valid_i / w_ready_o  in/out  1  write request handshake
- w_addr_i  in  64  write address; w_data_i  in  64  lane-aligned data; w_mask_i  in  8  byte strobes
- w_valid_o / w_ready_i  out/in  1  write-complete handshake
- r_valid_i / r_ready_o  in/out  1  read request handshake
- r_addr_i  in  64  read address; r_size_i  in  8  access bytes (1/2/4/8)
- data_valid_o / data_ready_i  out/in  1  read-data handshake; data_read_o  out  64  read beat
- awvalid/awready/awaddr, wvalid/wready/wdata/wstrb, bvalid/bready/bresp[1:0], arvalid/arready/araddr/arsize[2:0], rvalid/rready/rdata/rresp[1:0]: AXI4-Lite master, standard directions
- bus_err_o  out  1  sticky error flag (see Configuration)

## Operation
- FSM: IDLE, WR_REQ, WR_RESP, WR_DONE, RD_REQ, RD_RESP, RD_DONE.
- IDLE: w_ready_o = w_valid_i; r_ready_o = r_valid_i & ~w_valid_i (combinational; write wins a tie). On w handshake capture addr/data/mask, set awvalid=wvalid=1, go WR_REQ. On r handshake capture addr, encode arsize (1→0, 2→1, 4→2, 8→3, any other→3), set arvalid=1, go RD_REQ.
- Outside IDLE, w_ready_o = r_ready_o = 0; new requests wait.
- WR_REQ: awvalid and wvalid each drop independently on own ready; when both accepted (same or different cycles) set bready=1, go WR_RESP. Valids never depend on readys.
- WR_RESP: on bvalid&bready clear bready, set w_valid_o, go WR_DONE.
- WR_DONE: hold w_valid_o until w_ready_i; then clear, go IDLE.
- RD_REQ: arvalid drops on arready; set rready=1, go RD_RESP.
- RD_RESP: on rvalid&rready latch rdata into data_read_o, clear rready, set data_valid_o, go RD_DONE.
- RD_DONE: hold data_valid_o until data_ready_i; then clear, go IDLE. data_read_o holds its value until the next read beat.
- awaddr/araddr passed unaligned as captured; wstrb = captured mask unchanged.

## Timing
- Reset (async assert, sync-safe release): state=IDLE; all valid/ready outputs 0; awaddr, araddr, wdata, data_read_o = 0; wstrb=0; arsize=0; bus_err_o=0.
- Zero-wait slave, write: handshake cycle T; AW/W valid T+1; bready T+2 (bvalid same cycle); w_valid_o T+3; w_ready_i at T+3 → IDLE T+4. Read: same, data_valid_o at T+3 carrying rdata.
- Back-to-back: next request accepted earliest the cycle after the previous DONE handshake.
- Reset mid-transaction: state discarded, all AXI valids drop immediately; no completion reported.
- Slave stalls any number of cycles; no timeout.

## Configuration
- LSU_AXI_ERR_CHECK_EN defined: bresp or rresp ≠ OKAY (2'b00) sets bus_err_o, sticky until reset; transaction still completes normally. Undefined: responses ignored, bus_err_o tied 0.

## Test plan
- Write addr 0x8000_0010, data 0x1122334455667788, mask 0xFF, zero-wait slave → AW/W at T+1, w_valid_o at T+3, wstrb=0xFF.
- Read 0x8000_0008 size 4, slave rdata 0xDEADBEEF_CAFEF00D after 3-cycle arready stall → arsize=2, data_valid_o with that value, held while data_ready_i low for 2 cycles.
- w_valid_i and r_valid_i same cycle → write accepted first, read accepted cycle after write-complete handshake.
- Slave asserts wready 2 cycles before awready → bready only after both accepted; single B handshake.
- rresp=2'b10 with macro defined → bus_err_o=1 and stays 1; without macro stays 0.
- rst_n low during WR_RESP → all valids 0 that cycle; after release, new read completes normally.
